// File: rtl/pipe_stage_buf_if.sv
// Valid/ready/data handshake bundle between two pipeline stages.
interface pipe_stage_buf_if #(
    parameter int unsigned DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, flush with a saturating count of discarded entries.
module pipe_stage_buf #(
    parameter int unsigned       DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter bit                SKID_EN    = 1'b1,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    pipe_stage_buf_if.slave    up,
    pipe_stage_buf_if.master   dn,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    // Encoding equals the number of held entries, so occupancy is the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              main_v_q;
    logic              ready_q;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W:0]    cnt_sum;
    logic              accept;
    logic              emit;

    // main_q is forced to BUBBLE_VAL whenever empty, so out_data is a plain register.
    assign up.ready  = SKID_EN ? ready_q : (~main_v_q | dn.ready);
    assign dn.valid  = main_v_q;
    assign dn.data   = main_q;
    assign occupancy = 2'(state_q);

    assign accept = up.valid & up.ready;
    assign emit   = main_v_q & dn.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            main_v_q  <= 1'b0;
            ready_q   <= 1'b1;
            main_q    <= BUBBLE_VAL;
            skid_q    <= BUBBLE_VAL;
            flush_cnt <= '0;
        end else begin
            state_q   <= state_d;
            main_v_q  <= (state_d != EMPTY);
            ready_q   <= (state_d != TWO);
            main_q    <= main_d;
            skid_q    <= skid_d;
            flush_cnt <= cnt_d;
        end
    end

    // Next state; flush overrides any same-cycle accept or emit.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = flush_cnt;
        cnt_sum = {1'b0, flush_cnt} + (CNT_W+1)'(state_q);

        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
            cnt_d   = (cnt_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(cnt_sum);
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = up.data;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_d = up.data;
                    end else if (accept && SKID_EN) begin
                        state_d = TWO;
                        skid_d  = up.data;
                    end else if (emit) begin
                        state_d = EMPTY;
                        main_d  = BUBBLE_VAL;
                    end
                end
                TWO: begin
                    if (emit) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_VAL;
                    skid_d  = BUBBLE_VAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench: dut0 has the skid buffer (CNT_W=2), dut1 is a single register (CNT_W=4).
module tb_pipe_stage_buf;

    localparam int unsigned       DW  = 16;
    localparam logic [DW-1:0]     BUB = 16'h0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pipe_stage_buf_if #(.DATA_W(DW)) up0 ();
    pipe_stage_buf_if #(.DATA_W(DW)) dn0 ();
    pipe_stage_buf_if #(.DATA_W(DW)) up1 ();
    pipe_stage_buf_if #(.DATA_W(DW)) dn1 ();

    logic [1:0]    occ0, occ1, fc0;
    logic [3:0]    fc1;
    logic          fl   [2];
    logic          vin  [2];
    logic [DW-1:0] din  [2];
    logic          ordy [2];
    logic          rdy  [2];
    logic          ov   [2];
    logic [DW-1:0] od   [2];
    logic [1:0]    occ  [2];
    logic [7:0]    fcnt [2];

    assign up0.valid = vin[0];  assign up0.data = din[0];  assign dn0.ready = ordy[0];
    assign up1.valid = vin[1];  assign up1.data = din[1];  assign dn1.ready = ordy[1];
    assign rdy[0] = up0.ready;  assign ov[0] = dn0.valid;  assign od[0] = dn0.data;
    assign rdy[1] = up1.ready;  assign ov[1] = dn1.valid;  assign od[1] = dn1.data;
    assign occ[0] = occ0;       assign occ[1] = occ1;
    assign fcnt[0] = 8'(fc0);   assign fcnt[1] = 8'(fc1);

    pipe_stage_buf #(.DATA_W(DW), .BUBBLE_VAL(BUB), .SKID_EN(1'b1), .CNT_W(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(fl[0]), .up(up0), .dn(dn0),
        .occupancy(occ0), .flush_cnt(fc0));

    pipe_stage_buf #(.DATA_W(DW), .BUBBLE_VAL(BUB), .SKID_EN(1'b0), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(fl[1]), .up(up1), .dn(dn1),
        .occupancy(occ1), .flush_cnt(fc1));

    // Scoreboard: beats accepted and not yet emitted, per DUT, as a circular array.
    logic [DW-1:0] exp_mem [2][256];
    int  wr [2];
    int  rd [2];
    int  mcnt [2];
    bit  pend_fl [2];
    bit  pend_emit [2];
    int  tests = 0;
    int  fails = 0;
    bit  mon_en = 1'b0;

    // Upstream bookkeeping
    bit            busy [2];
    bit            acc  [2];
    bit            fl_s [2];
    bit            use_seq;
    logic [DW-1:0] seq  [2];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, expv, $time);
        end
    endtask

    // Monitor: retire last edge's emit/flush from the scoreboard, then compare every output.
    initial begin
        int sz;
        int cmax;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int k = 0; k < 2; k++) begin
                    cmax = (k == 0) ? 3 : 15;
                    sz   = wr[k] - rd[k];
                    if (pend_fl[k]) begin
                        mcnt[k] = (mcnt[k] + sz > cmax) ? cmax : mcnt[k] + sz;
                        rd[k]   = wr[k];
                    end else if (pend_emit[k]) begin
                        rd[k]++;
                    end
                    sz = wr[k] - rd[k];
                    chk("out_valid", k, 32'(ov[k]), 32'(sz > 0));
                    chk("out_data",  k, 32'(od[k]), (sz > 0) ? 32'(exp_mem[k][rd[k] & 255]) : 32'(BUB));
                    chk("occupancy", k, 32'(occ[k]), 32'(sz));
                    chk("flush_cnt", k, 32'(fcnt[k]), 32'(mcnt[k]));
                    chk("in_ready",  k, 32'(rdy[k]),
                        (k == 0) ? 32'(sz < 2) : 32'((sz == 0) || ordy[k]));
                    pend_fl[k]   = fl[k];
                    pend_emit[k] = (sz > 0) && ordy[k];
                end
            end
        end
    end

    // One upstream/downstream cycle per iteration; vp/rp/fp are percent probabilities.
    task automatic cyc(input int n, input int vp, input int rp, input int fp);
        for (int c = 0; c < n; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!busy[k]) begin
                    vin[k] = int'($urandom_range(99)) < vp;
                    din[k] = use_seq ? seq[k] : DW'($urandom);
                    if (vin[k] && use_seq) seq[k] = seq[k] + 1'b1;
                end
                ordy[k] = int'($urandom_range(99)) < rp;
                fl[k]   = int'($urandom_range(99)) < fp;
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                acc[k]  = vin[k] && rdy[k];
                fl_s[k] = fl[k];
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (acc[k] && !fl_s[k]) begin
                    exp_mem[k][wr[k] & 255] = din[k];
                    wr[k]++;
                end
                busy[k] = vin[k] && !acc[k];
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            vin[k] = 1'b0; din[k] = '0; ordy[k] = 1'b0; fl[k] = 1'b0;
            wr[k] = 0; rd[k] = 0; mcnt[k] = 0; busy[k] = 1'b0; seq[k] = '0;
        end
        use_seq = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", k, 32'(ov[k]), 32'd0);
            chk("rst_out_data",  k, 32'(od[k]), 32'(BUB));
            chk("rst_occupancy", k, 32'(occ[k]), 32'd0);
            chk("rst_flush_cnt", k, 32'(fcnt[k]), 32'd0);
            chk("rst_in_ready",  k, 32'(rdy[k]), 32'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Streaming 0x1..0x8
        seq[0] = 16'h1; seq[1] = 16'h1;
        cyc(8, 100, 100, 0);
        cyc(3, 0, 100, 0);

        // Backpressure with 0xA,0xB,0xC, then release
        seq[0] = 16'hA; seq[1] = 16'hA;
        cyc(3, 100, 0, 0);
        cyc(6, 0, 100, 0);

        // Three back-to-back flushes of a full stage with a beat offered
        for (int r = 0; r < 3; r++) begin
            cyc(2, 100, 0, 0);
            cyc(1, 100, 0, 100);
        end
        cyc(4, 0, 100, 0);

        // Random traffic
        use_seq = 1'b0;
        cyc(2000, 70, 60, 3);
        cyc(10, 0, 100, 0);

        // Asynchronous reset with entries held
        cyc(3, 100, 0, 0);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midrst_out_valid", k, 32'(ov[k]), 32'd0);
            chk("midrst_out_data",  k, 32'(od[k]), 32'(BUB));
            chk("midrst_occupancy", k, 32'(occ[k]), 32'd0);
            chk("midrst_flush_cnt", k, 32'(fcnt[k]), 32'd0);
            chk("midrst_in_ready",  k, 32'(rdy[k]), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
